bsg_tx_serializer: RTL and testbench

- Downstream stage of the bsg core. Accepts encoded data words over a valid/ready handshake and buffers them in a small FIFO.
- Each word is sent as a framed serial bit stream: start bit, DATA_WIDTH data bits LSB first, even parity bit, stop bit.
- Bit timing comes from an internal divider on SYS_CLK. There is no second clock.

---
 rtl/bsg_tx_pkg.sv | 8 +
 rtl/bsg_tx_fifo.sv | 49 ++++
 rtl/bsg_tx_serializer.sv | 105 ++++++++++
 tb/tb_bsg_tx_serializer.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bsg_tx_pkg.sv
// Shared types and line levels for the bsg serial transmitter.
package bsg_tx_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_t;

  localparam logic IDLE_LEVEL  = 1'b1;
  localparam logic START_LEVEL = 1'b0;
  localparam logic STOP_LEVEL  = 1'b1;
endpackage

// File: rtl/bsg_tx_fifo.sv
// Small synchronous FIFO feeding the serializer; read data is combinational from the head.
module bsg_tx_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                                  SYS_CLK,
  input  logic                                  rst,
  input  logic                                  push,
  input  logic                                  pop,
  input  logic [DATA_WIDTH-1:0]                 wr_data,
  output logic [DATA_WIDTH-1:0]                 rd_data,
  output logic                                  full,
  output logic                                  empty,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]       count
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH+1);

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]         wptr, rptr;
  logic                  do_push, do_pop;

  assign full    = (count == CW'(FIFO_DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rptr];

  // Storage is not reset; count/pointers alone define validity.
  always_ff @(posedge SYS_CLK) begin
    if (do_push) mem[wptr] <= wr_data;
  end

  always_ff @(posedge SYS_CLK or negedge rst) begin
    if (!rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop)  rptr <= rptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/bsg_tx_serializer.sv
// Framed serial transmitter: start, data LSB first, even parity, stop; back-to-back frames when buffered.
module bsg_tx_serializer
  import bsg_tx_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int FIFO_DEPTH   = 4,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic                              SYS_CLK,
  input  logic                              rst,
  input  logic                              in_valid,
  input  logic [DATA_WIDTH-1:0]             in_data,
  output logic                              in_ready,
  output logic                              tx_bit,
  output logic                              tx_active,
  output logic                              tx_done,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count
);
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  tx_state_t             state;
  logic                  enable;
  logic [CW-1:0]         bit_cnt;
  logic [IW-1:0]         bit_idx;
  logic [DATA_WIDTH-1:0] shreg, sh_next, rd_data;
  logic                  parity, full, empty, push, pop, bit_last;

  assign bit_last  = (bit_cnt == CW'(CLKS_PER_BIT-1));
  assign in_ready  = enable && !full;
  assign push      = in_valid && in_ready;
  // Pop from idle, or in the final stop cycle so the next start bit follows with no gap.
  assign pop       = !empty && ((state == IDLE) || (state == STOP && bit_last));
  assign tx_active = (state != IDLE);
  assign tx_done   = (state == STOP) && bit_last;
  assign sh_next   = shreg >> 1;

  bsg_tx_fifo #(.DATA_WIDTH(DATA_WIDTH), .FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .SYS_CLK (SYS_CLK),
    .rst     (rst),
    .push    (push),
    .pop     (pop),
    .wr_data (in_data),
    .rd_data (rd_data),
    .full    (full),
    .empty   (empty),
    .count   (fifo_count)
  );

  always_ff @(posedge SYS_CLK or negedge rst) begin
    if (!rst) enable <= 1'b0;
    else      enable <= 1'b1;
  end

  always_ff @(posedge SYS_CLK or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      bit_cnt <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      parity  <= 1'b0;
      tx_bit  <= IDLE_LEVEL;
    end else begin
      bit_cnt <= bit_last ? '0 : bit_cnt + CW'(1);
      if (pop) begin
        shreg   <= rd_data;
        parity  <= ^rd_data;
        state   <= START;
        bit_cnt <= '0;
        tx_bit  <= START_LEVEL;
      end else begin
        case (state)
          IDLE: begin
            bit_cnt <= '0;
            tx_bit  <= IDLE_LEVEL;
          end
          START: if (bit_last) begin
            state   <= DATA;
            bit_idx <= '0;
            tx_bit  <= shreg[0];
          end
          DATA: if (bit_last) begin
            if (bit_idx == IW'(DATA_WIDTH-1)) begin
              state  <= PARITY;
              tx_bit <= parity;
            end else begin
              shreg   <= sh_next;
              bit_idx <= bit_idx + IW'(1);
              tx_bit  <= sh_next[0];
            end
          end
          PARITY: if (bit_last) begin
            state  <= STOP;
            tx_bit <= STOP_LEVEL;
          end
          STOP: if (bit_last) begin
            state  <= IDLE;
            tx_bit <= IDLE_LEVEL;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_bsg_tx_serializer.sv
// Randomized and directed bench for bsg_tx_serializer against a frame-level reference model.
module tb_bsg_tx_serializer;
  localparam int W = 8, D = 4, C = 4, FRAME = (W+3)*C, CNTW = $clog2(D+1);

  logic SYS_CLK = 1'b0;
  always #5 SYS_CLK = ~SYS_CLK;

  logic            rst, in_valid, in_valid1;
  logic [W-1:0]    in_data, in_data1;
  logic            in_ready, tx_bit, tx_active, tx_done;
  logic            in_ready1, tx_bit1, tx_active1, tx_done1;
  logic [CNTW-1:0] fifo_count, fifo_count1;

  bsg_tx_serializer #(.DATA_WIDTH(W), .FIFO_DEPTH(D), .CLKS_PER_BIT(C)) u_dut (
    .SYS_CLK(SYS_CLK), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .tx_bit(tx_bit), .tx_active(tx_active), .tx_done(tx_done), .fifo_count(fifo_count));

  bsg_tx_serializer #(.DATA_WIDTH(W), .FIFO_DEPTH(D), .CLKS_PER_BIT(1)) u_dut1 (
    .SYS_CLK(SYS_CLK), .rst(rst), .in_valid(in_valid1), .in_data(in_data1), .in_ready(in_ready1),
    .tx_bit(tx_bit1), .tx_active(tx_active1), .tx_done(tx_done1), .fifo_count(fifo_count1));

  int total = 0, bad = 0;

  // Reference model: words waiting, word on the line, and cycle position within its frame (-1 idle).
  logic [W-1:0] mq[$];
  logic [W-1:0] cur;
  int           fpos = -1;
  bit           m_en = 1'b0;

  wire [4+CNTW-1:0] obs = {tx_bit, tx_active, tx_done, in_ready, fifo_count};

  function automatic logic frame_bit(logic [W-1:0] w, int cyc);
    int p = cyc / C;
    if (p == 0) return 1'b0;
    if (p <= W) return w[p-1];
    if (p == W+1) return ($countones(w) % 2) == 1;
    return 1'b1;
  endfunction

  function automatic logic [4+CNTW-1:0] exp_vec();
    logic b = (fpos < 0) ? 1'b1 : frame_bit(cur, fpos);
    return {b, fpos >= 0, fpos == FRAME-1, m_en && (mq.size() != D), CNTW'(mq.size())};
  endfunction

  function automatic bit model_idle();
    return fpos < 0 && mq.size() == 0;
  endfunction

  task automatic model_reset();
    mq.delete();
    fpos = -1;
    m_en = 1'b0;
  endtask

  // One clock: drive at negedge, advance the model at posedge, return at the next negedge.
  task automatic tick(input logic v, input logic [W-1:0] d, output bit acc);
    bit do_pop;
    in_valid = v;
    in_data  = d;
    acc = v && m_en && (mq.size() != D);
    @(posedge SYS_CLK);
    do_pop = (mq.size() > 0) && (fpos < 0 || fpos == FRAME-1);
    if (do_pop) begin
      cur  = mq.pop_front();
      fpos = 0;
    end else if (fpos == FRAME-1) fpos = -1;
    else if (fpos >= 0) fpos++;
    if (acc) mq.push_back(d);
    m_en = 1'b1;
    @(negedge SYS_CLK);
  endtask

  task automatic test_reset();
    bit acc;
    rst = 1'b0; in_valid = 1'b0; in_data = '0; in_valid1 = 1'b0; in_data1 = '0;
    model_reset();
    for (int i = 0; i < 2; i++) begin
      @(negedge SYS_CLK);
      total++;
      if (obs !== {1'b1, 1'b0, 1'b0, 1'b0, CNTW'(0)}) begin
        bad++; $display("FAIL reset_values got=%b want=%b", obs, {1'b1, 3'b000, CNTW'(0)});
      end
    end
    rst = 1'b1;
    #1;
    total++;
    if (in_ready !== 1'b0) begin bad++; $display("FAIL ready_before_edge got=%b want=0", in_ready); end
    @(negedge SYS_CLK);
    tick(1'b0, '0, acc);
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL ready_after_edge got=%b want=1", in_ready); end
  endtask

  task automatic test_single();
    bit acc;
    int act_cnt = 0, done_cnt = 0, done_at = -1;
    logic [10:0] seq = '0, want;
    want = 11'b10101001010;
    tick(1'b1, 8'hA5, acc);
    total++;
    if (obs !== exp_vec()) begin bad++; $display("FAIL single_push got=%b want=%b", obs, exp_vec()); end
    for (int n = 0; n < FRAME+2; n++) begin
      tick(1'b0, '0, acc);
      total++;
      if (obs !== exp_vec()) begin bad++; $display("FAIL single_cycle%0d got=%b want=%b", n, obs, exp_vec()); end
      if (tx_active) act_cnt++;
      if (tx_done) begin done_cnt++; done_at = n; end
      if (n < FRAME && n % C == 0) seq[n/C] = tx_bit;
    end
    total++;
    if (seq !== want) begin bad++; $display("FAIL single_bits got=%b want=%b", seq, want); end
    total++;
    if (act_cnt != FRAME) begin bad++; $display("FAIL single_active_len got=%0d want=%0d", act_cnt, FRAME); end
    total++;
    if (done_cnt != 1 || done_at != FRAME-1) begin
      bad++; $display("FAIL single_done got=%0d@%0d want=1@%0d", done_cnt, done_at, FRAME-1);
    end
  endtask

  task automatic test_parity();
    logic [W-1:0] words [3];
    logic         want  [3];
    logic         got;
    bit acc;
    words = '{8'h01, 8'hFF, 8'h00};
    want  = '{1'b1, 1'b0, 1'b0};
    for (int k = 0; k < 3; k++) begin
      got = 1'bx;
      tick(1'b1, words[k], acc);
      for (int n = 0; n < FRAME+1; n++) begin
        tick(1'b0, '0, acc);
        total++;
        if (obs !== exp_vec()) begin bad++; $display("FAIL parity_cycle got=%b want=%b", obs, exp_vec()); end
        if (n == (W+1)*C + 1) got = tx_bit;
      end
      total++;
      if (got !== want[k]) begin bad++; $display("FAIL parity_%h got=%b want=%b", words[k], got, want[k]); end
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] w [7];
    logic [W-1:0] base;
    int dones[$];
    int acc_n = 0, pend = 0, fp_seen = 0, cyc = 0;
    bit acc, seen5 = 1'b0;
    base = W'($urandom);
    for (int k = 0; k < 7; k++) w[k] = base + W'(k*37);
    while (cyc < 400 && !(acc_n == 6 && model_idle())) begin
      if (acc_n < 6 && tx_done && fifo_count == CNTW'(D)) begin
        fp_seen++;
        total++;
        if (in_ready !== 1'b0) begin bad++; $display("FAIL full_pop_ready got=%b want=0", in_ready); end
        pend = 1;
      end
      tick(acc_n < 6, w[acc_n], acc);
      if (acc) acc_n++;
      total++;
      if (obs !== exp_vec()) begin bad++; $display("FAIL b2b_cycle%0d got=%b want=%b", cyc, obs, exp_vec()); end
      if (pend == 1) begin
        total++;
        if ({in_ready, fifo_count} !== {1'b1, CNTW'(D-1)}) begin
          bad++; $display("FAIL full_pop_after got=%b want=%b", {in_ready, fifo_count}, {1'b1, CNTW'(D-1)});
        end
        pend = 2;
      end else if (pend == 2) begin
        total++;
        if (fifo_count !== CNTW'(D)) begin bad++; $display("FAIL full_pop_refill got=%0d want=%0d", fifo_count, D); end
        pend = 0;
      end
      if (acc_n == 5 && !seen5) begin
        seen5 = 1'b1;
        total++;
        if ({in_ready, fifo_count} !== {1'b0, CNTW'(D)}) begin
          bad++; $display("FAIL b2b_fill got=%b want=%b", {in_ready, fifo_count}, {1'b0, CNTW'(D)});
        end
      end
      if (tx_done) dones.push_back(cyc);
      cyc++;
    end
    in_valid = 1'b0;
    total++;
    if (cyc >= 400) begin bad++; $display("FAIL b2b_timeout got=%0d want<400", cyc); end
    total++;
    if (fp_seen != 1) begin bad++; $display("FAIL full_pop_seen got=%0d want=1", fp_seen); end
    total++;
    if (dones.size() != 6) begin bad++; $display("FAIL b2b_done_count got=%0d want=6", dones.size()); end
    for (int k = 1; k < dones.size(); k++) begin
      total++;
      if (dones[k] - dones[k-1] != FRAME) begin
        bad++; $display("FAIL b2b_spacing got=%0d want=%0d", dones[k] - dones[k-1], FRAME);
      end
    end
  endtask

  task automatic test_random();
    bit acc;
    int cyc = 0;
    for (int i = 0; i < 400; i++) begin
      tick($urandom_range(0, 2) == 0, W'($urandom), acc);
      total++;
      if (obs !== exp_vec()) begin bad++; $display("FAIL rand_cycle%0d got=%b want=%b", i, obs, exp_vec()); end
    end
    while (cyc < 300 && !model_idle()) begin
      tick(1'b0, '0, acc);
      total++;
      if (obs !== exp_vec()) begin bad++; $display("FAIL rand_drain got=%b want=%b", obs, exp_vec()); end
      cyc++;
    end
    total++;
    if (cyc >= 300) begin bad++; $display("FAIL rand_drain_timeout got=%0d want<300", cyc); end
  endtask

  task automatic test_reset_midframe();
    bit acc;
    int cyc = 0;
    for (int k = 0; k < 3; k++) tick(1'b1, W'($urandom), acc);
    in_valid = 1'b0;
    while (cyc < 100 && fpos != 4*C + 1) begin tick(1'b0, '0, acc); cyc++; end
    total++;
    if (fifo_count !== CNTW'(2)) begin bad++; $display("FAIL midrst_pre_count got=%0d want=2", fifo_count); end
    rst = 1'b0;
    model_reset();
    #1;
    total++;
    if (obs !== {1'b1, 3'b000, CNTW'(0)}) begin bad++; $display("FAIL midrst_immediate got=%b want=%b", obs, {1'b1, 3'b000, CNTW'(0)}); end
    repeat (2) @(negedge SYS_CLK);
    total++;
    if (obs !== {1'b1, 3'b000, CNTW'(0)}) begin bad++; $display("FAIL midrst_held got=%b want=%b", obs, {1'b1, 3'b000, CNTW'(0)}); end
    rst = 1'b1;
    tick(1'b0, '0, acc);
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL midrst_ready got=%b want=1", in_ready); end
    tick(1'b1, W'($urandom), acc);
    for (int n = 0; n < FRAME+2; n++) begin
      tick(1'b0, '0, acc);
      total++;
      if (obs !== exp_vec()) begin bad++; $display("FAIL midrst_frame got=%b want=%b", obs, exp_vec()); end
    end
  endtask

  task automatic test_cpb1();
    logic [10:0] want;
    want = 11'b10001111000;
    @(negedge SYS_CLK);
    in_valid1 = 1'b1; in_data1 = 8'h3C;
    @(negedge SYS_CLK);
    in_valid1 = 1'b0;
    for (int n = 0; n < 13; n++) begin
      @(negedge SYS_CLK);
      total++;
      if ({tx_bit1, tx_active1, tx_done1} !== {(n < 11) ? want[n] : 1'b1, n < 11, n == 10}) begin
        bad++;
        $display("FAIL cpb1_cycle%0d got=%b want=%b", n + 1, {tx_bit1, tx_active1, tx_done1},
                 {(n < 11) ? want[n] : 1'b1, n < 11, n == 10});
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_parity();
    test_back_to_back();
    test_random();
    test_reset_midframe();
    test_cpb1();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1);
  end
endmodule
